// File: rtl/hynoc_stream_pkg.sv
// Definitions shared by the HyNoC stream writer and reader: payload LFSR
// polynomial, header field layout, EOP position and FSM state encoding.
package hynoc_stream_pkg;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  localparam int HDR_ID_MSB  = 31;
  localparam int HDR_ID_LSB  = 16;
  localparam int HDR_IDX_MSB = 15;
  localparam int HDR_IDX_LSB = 0;

  typedef logic [1:0] state_t;

  localparam state_t S_HDR  = 2'd0;
  localparam state_t S_DATA = 2'd1;
  localparam state_t S_DONE = 2'd2;

  // EOP sits directly above the payload
  function automatic int eop_bit(input int payload_width);
    return payload_width;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/hynoc_stream_lfsr.sv
// Seedable 32-bit Galois LFSR; value shows the current word and steps once
// per cycle with adv high.
module hynoc_stream_lfsr
  import hynoc_stream_pkg::*;
#(
  parameter logic [31:0] SEED = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [31:0] value
);

  logic [31:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q;

endmodule

// File: rtl/hynoc_stream_reader.sv
// HyNoC stream reader: drains the egress FIFO and checks headers and LFSR payload.
// Build option HYNOC_STREAM_READER_RANDOM_WAIT_EN adds random idle gaps after each packet.
//
//   state  | meaning
//   S_HDR  | next captured flit is a header (ID + packet index)
//   S_DATA | captured flits are payload words checked against the LFSR
//   S_DONE | NB_PACKETS received; no further pops until reset
module hynoc_stream_reader
  import hynoc_stream_pkg::*;
#(
  parameter int          READER_CHECKER_ID = 0,
  parameter logic [31:0] FLIT_RANDOM_SEED  = 32'd556,
  parameter int          NB_PACKETS        = 100,
  parameter int          MAX_NB_FLITS      = 1024,
  parameter int          MAX_WAIT          = 1024,
  parameter int          LOG2_FIFO_DEPTH   = 5,
  parameter int          PAYLOAD_WIDTH     = 32,
  parameter int          FLIT_WIDTH        = PAYLOAD_WIDTH + 1
) (
  input  logic                       local_clk,
  input  logic                       local_arst,
  output logic                       local_egress_read,
  input  logic [FLIT_WIDTH-1:0]      local_egress_data,
  input  logic [LOG2_FIFO_DEPTH:0]   local_egress_fifo_level,
  output logic                       packet_received,
  output logic                       all_packets_received,
  output logic                       error,
  output logic [15:0]                error_count,
  output logic [15:0]                packet_count
);

  localparam int EOP   = eop_bit(PAYLOAD_WIDTH);
  localparam int CNT_W = $clog2(MAX_NB_FLITS + 1);

  if (PAYLOAD_WIDTH < 32 || FLIT_WIDTH != PAYLOAD_WIDTH + 1 || MAX_WAIT < 0) begin : g_param_check
    $error("hynoc_stream_reader: unsupported parameter combination");
  end

  state_t            state_q, state_d;
  logic              run_q, rd_q, rd_d;
  logic [15:0]       idx_q, idx_d, pkt_cnt_q, pkt_cnt_d, err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]  flit_cnt_q, flit_cnt_d;
  logic              pkt_rx_q, pkt_rx_d, done_q, done_d, err_q, err_d;
  logic              eop, hdr_ok, data_ok, err_hit, lfsr_adv, wait_ok;
  logic [31:0]       payload, lfsr_val;

  hynoc_stream_lfsr #(.SEED(FLIT_RANDOM_SEED)) u_data_lfsr (
    .clk   (local_clk),
    .rst   (local_arst),
    .adv   (lfsr_adv),
    .value (lfsr_val)
  );

  assign payload = local_egress_data[31:0];
  assign eop     = local_egress_data[EOP];
  assign hdr_ok  = (payload[HDR_ID_MSB:HDR_ID_LSB] == 16'(READER_CHECKER_ID)) &&
                   (payload[HDR_IDX_MSB:HDR_IDX_LSB] == idx_q);
  assign data_ok = (payload == lfsr_val);

  // The level lags a pop by one cycle, so an in-flight read is subtracted.
  assign local_egress_read = run_q && wait_ok && (state_q != S_DONE) &&
                             (local_egress_fifo_level > {{LOG2_FIFO_DEPTH{1'b0}}, rd_q});

  always_comb begin
    rd_d       = local_egress_read;
    state_d    = state_q;
    idx_d      = idx_q;
    flit_cnt_d = flit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    pkt_rx_d   = 1'b0;
    done_d     = done_q;
    err_hit    = 1'b0;
    lfsr_adv   = 1'b0;
    if (rd_q) begin
      case (state_q)
        S_HDR: begin
          err_hit    = !hdr_ok;
          flit_cnt_d = '0;
          if (eop) pkt_rx_d = 1'b1;
          else     state_d  = S_DATA;
        end
        S_DATA: begin
          lfsr_adv = 1'b1;
          // One flit past the maximum: flag it and treat what follows as headers.
          if (flit_cnt_q == CNT_W'(MAX_NB_FLITS)) begin
            err_hit = 1'b1;
            state_d = S_HDR;
          end else begin
            err_hit    = !data_ok;
            flit_cnt_d = flit_cnt_q + CNT_W'(1);
            if (eop) begin
              pkt_rx_d = 1'b1;
              state_d  = S_HDR;
            end
          end
        end
        default: ;
      endcase
    end
    if (pkt_rx_d) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
      idx_d     = idx_q + 16'd1;
    end
    if (pkt_cnt_q == 16'(NB_PACKETS)) begin
      state_d = S_DONE;
      done_d  = 1'b1;
    end
    err_d     = err_q | err_hit;
    err_cnt_d = (err_hit && (err_cnt_q != 16'hFFFF)) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge local_clk or posedge local_arst) begin
    if (local_arst) begin
      state_q    <= S_HDR;
      run_q      <= 1'b0;
      rd_q       <= 1'b0;
      idx_q      <= '0;
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      err_cnt_q  <= '0;
      pkt_rx_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      rd_q       <= rd_d;
      idx_q      <= idx_d;
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      pkt_rx_q   <= pkt_rx_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef HYNOC_STREAM_READER_RANDOM_WAIT_EN
  localparam int WAIT_W = $clog2(MAX_WAIT + 2);

  logic [31:0]       wait_rand;
  logic [WAIT_W-1:0] wait_q, wait_d;

  hynoc_stream_lfsr #(.SEED(FLIT_RANDOM_SEED ^ 32'h5A5A_5A5A)) u_wait_lfsr (
    .clk   (local_clk),
    .rst   (local_arst),
    .adv   (pkt_rx_d),
    .value (wait_rand)
  );

  always_comb begin
    wait_d = wait_q;
    if (pkt_rx_d)            wait_d = WAIT_W'(wait_rand % 32'(MAX_WAIT + 1));
    else if (wait_q != '0)   wait_d = wait_q - WAIT_W'(1);
  end

  always_ff @(posedge local_clk or posedge local_arst) begin
    if (local_arst) wait_q <= '0;
    else            wait_q <= wait_d;
  end

  assign wait_ok = (wait_q == '0);
`else
  assign wait_ok = 1'b1;
`endif

  assign packet_received      = pkt_rx_q;
  assign all_packets_received = done_q;
  assign error                = err_q;
  assign error_count          = err_cnt_q;
  assign packet_count         = pkt_cnt_q;

endmodule

// File: tb/tb_hynoc_stream_reader.sv
// Bench for hynoc_stream_reader: reference writer into a FIFO model, with a
// per-packet scoreboard checked on every packet_received pulse.
`timescale 1ns/1ps
module tb_hynoc_stream_reader;

  localparam int          NB    = 100;
  localparam int          MAXF  = 8;
  localparam int          L2D   = 5;
  localparam int          LW    = L2D + 1;
  localparam int          FW    = 33;
  localparam int          DEPTH = 32;
  localparam logic [31:0] SEED  = 32'd556;
  localparam logic [15:0] CHK_ID = 16'h0000;

  logic          local_clk = 1'b0;
  logic          local_arst;
  logic          local_egress_read;
  logic [FW-1:0] egress_data = '0;
  logic [LW-1:0] level_r = '0;
  logic          packet_received, all_packets_received, error;
  logic [15:0]   error_count, packet_count;

  hynoc_stream_reader #(
    .READER_CHECKER_ID (0),
    .FLIT_RANDOM_SEED  (SEED),
    .NB_PACKETS        (NB),
    .MAX_NB_FLITS      (MAXF),
    .MAX_WAIT          (16),
    .LOG2_FIFO_DEPTH   (L2D),
    .PAYLOAD_WIDTH     (32),
    .FLIT_WIDTH        (FW)
  ) dut (
    .local_clk               (local_clk),
    .local_arst              (local_arst),
    .local_egress_read       (local_egress_read),
    .local_egress_data       (egress_data),
    .local_egress_fifo_level (level_r),
    .packet_received         (packet_received),
    .all_packets_received    (all_packets_received),
    .error                   (error),
    .error_count             (error_count),
    .packet_count            (packet_count)
  );

  always #5 local_clk = ~local_clk;

  typedef struct packed { logic [15:0] pkt; logic [15:0] err; } exp_t;

  exp_t          sb_q[$];
  logic [FW-1:0] fifo_q[$];
  int            eop_cyc_q[$];
  int            cyc = 0, n_cmp = 0, n_bad = 0, underflow = 0, consec = 0, n_pulses = 0;
  int            base_pulses = 0, base_consec = 0;
  bit            hold1 = 1'b0;
  logic          prev_read = 1'b0;
  exp_t          mon_e;
  logic [31:0]   m_lfsr;
  logic [15:0]   m_idx, m_pkt, m_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ ((32'd1 << 31) | (32'd1 << 21) | (32'd1 << 1) | 32'd1);
    return n;
  endfunction

  // FIFO model: data valid the cycle after a pop, level one cycle stale.
  always @(posedge local_clk) begin
    level_r <= LW'(fifo_q.size());
    if (local_egress_read) begin
      if (fifo_q.size() == 0) underflow++;
      else begin
        if (fifo_q[0][FW-1]) eop_cyc_q.push_back(cyc);
        egress_data <= fifo_q.pop_front();
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge local_clk) begin
    if (hold1 && local_egress_read && prev_read) consec++;
    prev_read <= local_egress_read;
    if (packet_received) begin
      n_pulses++;
      check_val("sb_has_entry", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check_val("pkt_count", packet_count, mon_e.pkt);
        check_val("err_count", error_count, mon_e.err);
      end
      check_val("eop_popped", 32'(eop_cyc_q.size() != 0), 1);
      if (eop_cyc_q.size() != 0) check_val("latency", cyc - eop_cyc_q.pop_front(), 2);
    end
  end

  task automatic push_flit(input logic [FW-1:0] f);
    int guard = 0;
    while (fifo_q.size() >= (hold1 ? 1 : DEPTH) && guard < 5000) begin
      @(negedge local_clk);
      guard++;
    end
    if (guard >= 5000) check_val("push_timeout", 32'(guard), 0);
    else fifo_q.push_back(f);
  endtask

  task automatic send_packet(input int len, input logic [15:0] id, input int flip_at, input bit close);
    logic [31:0] d;
    push_flit({1'b0, id, m_idx});
    if (id != CHK_ID) m_err++;
    for (int i = 0; i < len; i++) begin
      d = m_lfsr;
      if (i == flip_at) begin
        d[8] = ~d[8];
        m_err++;
      end
      m_lfsr = ref_lfsr(m_lfsr);
      push_flit({close && (i == len - 1), d});
    end
    if (close) begin
      m_pkt++;
      m_idx++;
      sb_q.push_back(exp_t'{pkt: m_pkt, err: m_err});
    end
  endtask

  task automatic run_stream(input int n, input int flip_pkt);
    int len;
    for (int p = 0; p < n; p++) begin
      len = $urandom_range(MAXF, 1);
      if (p == flip_pkt && len < 4) len = 4;
      send_packet(len, CHK_ID, (p == flip_pkt) ? 3 : -1, 1'b1);
    end
  endtask

  task automatic do_reset();
    @(negedge local_clk);
    local_arst = 1'b1;
    fifo_q.delete();
    sb_q.delete();
    eop_cyc_q.delete();
    hold1  = 1'b0;
    m_lfsr = SEED;
    m_idx  = '0;
    m_pkt  = '0;
    m_err  = '0;
    repeat (3) @(negedge local_clk);
    local_arst  = 1'b0;
    base_pulses = n_pulses;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (fifo_q.size() != 0 && g < 5000) begin
      @(negedge local_clk);
      g++;
    end
    if (g >= 5000) check_val("drain_timeout", 32'(fifo_q.size()), 0);
    repeat (6) @(negedge local_clk);
  endtask

  task automatic wait_done();
    int g = 0;
    while (!all_packets_received && g < 10000) begin
      @(negedge local_clk);
      g++;
    end
    check_val("all_received", all_packets_received, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    local_arst = 1'b0;
    #1 local_arst = 1'b1;
    repeat (2) @(negedge local_clk);
    check_val("rst_read", local_egress_read, 0);
    check_val("rst_pkt_rx", packet_received, 0);
    check_val("rst_all", all_packets_received, 0);
    check_val("rst_error", error, 0);
    check_val("rst_err_cnt", error_count, 0);
    check_val("rst_pkt_cnt", packet_count, 0);

    // clean stream of NB packets, then S_DONE must ignore a waiting flit
    do_reset();
    run_stream(NB, -1);
    wait_done();
    check_val("clean_pkt_cnt", packet_count, NB);
    check_val("clean_error", error, 0);
    check_val("clean_err_cnt", error_count, 0);
    check_val("clean_pulses", 32'(n_pulses - base_pulses), NB);
    check_val("clean_sb_left", 32'(sb_q.size()), 0);
    push_flit({1'b0, CHK_ID, 16'd100});
    repeat (4) @(negedge local_clk);
    check_val("done_no_pop", 32'(fifo_q.size()), 1);

    // single flipped payload bit in packet 5
    do_reset();
    run_stream(NB, 5);
    wait_done();
    check_val("flip_error", error, 1);
    check_val("flip_err_cnt", error_count, 1);
    check_val("flip_pkt_cnt", packet_count, NB);

    // wrong writer ID in one header
    do_reset();
    send_packet(3, CHK_ID, -1, 1'b1);
    send_packet(2, 16'h0001, -1, 1'b1);
    send_packet(3, CHK_ID, -1, 1'b1);
    wait_idle();
    check_val("hdr_err_cnt", error_count, 1);
    check_val("hdr_pkt_cnt", packet_count, 3);

    // MAXF+1 data flits without EOP, then a normal packet must resync
    do_reset();
    send_packet(MAXF + 1, CHK_ID, -1, 1'b0);
    m_err++;
    wait_idle();
    check_val("ovf_err_cnt", error_count, 1);
    check_val("ovf_pkt_cnt", packet_count, 0);
    send_packet(2, CHK_ID, -1, 1'b1);
    wait_idle();
    check_val("resync_pkt_cnt", packet_count, 1);
    check_val("resync_err_cnt", error_count, 1);

    // FIFO level held at one
    do_reset();
    hold1 = 1'b1;
    base_consec = consec;
    for (int p = 0; p < 3; p++) send_packet(p + 2, CHK_ID, -1, 1'b1);
    wait_idle();
    check_val("lvl1_consec", 32'(consec - base_consec), 0);
    check_val("lvl1_pkt_cnt", packet_count, 3);
    check_val("lvl1_err_cnt", error_count, 0);
    hold1 = 1'b0;

    // async reset in the middle of packet 40, then a full rerun
    do_reset();
    run_stream(40, -1);
    send_packet(2, CHK_ID, -1, 1'b0);
    wait_idle();
    check_val("mid_pkt_cnt", packet_count, 40);
    #3 local_arst = 1'b1;
    #1;
    check_val("arst_read", local_egress_read, 0);
    check_val("arst_pkt_cnt", packet_count, 0);
    check_val("arst_err_cnt", error_count, 0);
    check_val("arst_error", error, 0);
    check_val("arst_all", all_packets_received, 0);
    check_val("arst_pkt_rx", packet_received, 0);
    do_reset();
    run_stream(NB, -1);
    wait_done();
    check_val("rerun_pkt_cnt", packet_count, NB);
    check_val("rerun_error", error, 0);
    check_val("rerun_pulses", 32'(n_pulses - base_pulses), NB);

    check_val("underflow", 32'(underflow), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
